// File: rtl/nco_pkg.sv
// Shared types and constants for the nco_sig tuning path.
package nco_pkg;

  localparam int NCO_REGISTER_WIDTH = 64;
  localparam int NCO_DWELL_WIDTH    = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RAMP   = 2'd1,
    SETTLE = 2'd2
  } nco_tune_state_t;

  typedef struct packed {
    logic [NCO_REGISTER_WIDTH-1:0] target;
    logic [NCO_REGISTER_WIDTH-1:0] step;
    logic [NCO_DWELL_WIDTH-1:0]    dwell;
  } nco_tune_req_t;

endpackage

// File: rtl/nco_dwell_timer.sv
// Loadable down-counter with zero flag; paces both ramp dwell and settle time.
module nco_dwell_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             count_en,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count_en && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/nco_tune_ctrl.sv
// Slewed retune controller driving the nco_sig phase increment.
// Define NCO_TUNE_RAMP_EN for bounded-step ramping; otherwise targets are applied in one jump.
module nco_tune_ctrl import nco_pkg::*; #(
  parameter int REGISTER_WIDTH = NCO_REGISTER_WIDTH,
  parameter int DWELL_WIDTH    = NCO_DWELL_WIDTH,
  parameter int SETTLE_CYCLES  = 8,
  parameter logic [REGISTER_WIDTH-1:0] RESET_INC = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      tune_valid,
  output logic                      tune_ready,
  input  logic [REGISTER_WIDTH-1:0] tune_target,
  input  logic [REGISTER_WIDTH-1:0] tune_step,
  input  logic [DWELL_WIDTH-1:0]    tune_dwell,
  input  logic                      abort,
  output logic [REGISTER_WIDTH-1:0] phase_increment,
  output logic                      busy,
  output logic                      locked,
  output logic                      done
);

  localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
  localparam int CNT_W    = (DWELL_WIDTH > SETTLE_W) ? DWELL_WIDTH : SETTLE_W;

  nco_tune_state_t state;
  nco_tune_req_t   req;
  logic            tmr_load;
  logic            tmr_en;
  logic            tmr_zero;
  logic [CNT_W-1:0] tmr_val;

`ifdef NCO_TUNE_RAMP_EN
  logic [REGISTER_WIDTH-1:0] nxt_inc;

  // Unsigned distance compare; moving by step only when strictly short of target
  // guarantees no overshoot and no modular wrap.
  function automatic logic [REGISTER_WIDTH-1:0] step_toward(
    input logic [REGISTER_WIDTH-1:0] cur,
    input logic [REGISTER_WIDTH-1:0] tgt,
    input logic [REGISTER_WIDTH-1:0] stp
  );
    logic [REGISTER_WIDTH-1:0] dist;
    dist = (tgt >= cur) ? (tgt - cur) : (cur - tgt);
    if (stp == '0 || dist <= stp) return tgt;
    else if (tgt > cur)           return cur + stp;
    else                          return cur - stp;
  endfunction

  assign nxt_inc = step_toward(phase_increment, req.target, req.step);
`else
  logic unused_ramp;
  assign unused_ramp = ^{req.step, req.dwell};
`endif

  assign tune_ready = (state == IDLE);
  assign busy       = (state != IDLE);

  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_en   = 1'b0;
    unique case (state)
      IDLE: begin
        if (tune_valid) begin
          tmr_load = 1'b1;
`ifdef NCO_TUNE_RAMP_EN
          tmr_val = (tune_target == phase_increment) ? CNT_W'(SETTLE_CYCLES - 1)
                                                     : CNT_W'(tune_dwell);
`else
          // One extra count covers the cycle in which the target is applied.
          tmr_val = CNT_W'(SETTLE_CYCLES);
`endif
        end
      end
`ifdef NCO_TUNE_RAMP_EN
      RAMP: begin
        if (tmr_zero) begin
          tmr_load = 1'b1;
          tmr_val  = (nxt_inc == req.target) ? CNT_W'(SETTLE_CYCLES - 1)
                                             : CNT_W'(req.dwell);
        end else begin
          tmr_en = 1'b1;
        end
      end
`endif
      SETTLE: tmr_en = 1'b1;
      default: ;
    endcase
  end

  nco_dwell_timer #(.WIDTH(CNT_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (tmr_load),
    .load_value (tmr_val),
    .count_en   (tmr_en),
    .zero       (tmr_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      req             <= '0;
      phase_increment <= RESET_INC;
      locked          <= 1'b0;
      done            <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (tune_valid) begin
            req    <= '{target: tune_target, step: tune_step, dwell: tune_dwell};
            locked <= 1'b0;
`ifdef NCO_TUNE_RAMP_EN
            state  <= (tune_target == phase_increment) ? SETTLE : RAMP;
`else
            state  <= SETTLE;
`endif
          end
        end
`ifdef NCO_TUNE_RAMP_EN
        RAMP: begin
          if (abort) begin
            state <= IDLE;
          end else if (tmr_zero) begin
            phase_increment <= nxt_inc;
            if (nxt_inc == req.target) state <= SETTLE;
          end
        end
`endif
        SETTLE: begin
          if (abort) begin
            state <= IDLE;
          end else begin
`ifndef NCO_TUNE_RAMP_EN
            phase_increment <= req.target;
`endif
            if (tmr_zero) begin
              done   <= 1'b1;
              locked <= 1'b1;
              state  <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nco_tune_ctrl.sv
// Directed bench for nco_tune_ctrl; follows NCO_TUNE_RAMP_EN to pick ramp or jump vectors.
module tb_nco_tune_ctrl;

  localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] NEAR = 64'hFFFF_FFFF_FFFF_FFFB;
  localparam logic [63:0] HALF = 64'h8000_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tune_valid = 1'b0;
  logic        tune_ready;
  logic [63:0] tune_target = '0;
  logic [63:0] tune_step = '0;
  logic [15:0] tune_dwell = '0;
  logic        abort = 1'b0;
  logic [63:0] phase_increment;
  logic        busy;
  logic        locked;
  logic        done;

  int errors = 0;
  int checks = 0;

  nco_tune_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .tune_valid      (tune_valid),
    .tune_ready      (tune_ready),
    .tune_target     (tune_target),
    .tune_step       (tune_step),
    .tune_dwell      (tune_dwell),
    .abort           (abort),
    .phase_increment (phase_increment),
    .busy            (busy),
    .locked          (locked),
    .done            (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic request(input logic [63:0] tgt, input logic [63:0] stp, input logic [15:0] dw);
    tune_target = tgt;
    tune_step   = stp;
    tune_dwell  = dw;
    tune_valid  = 1'b1;
    tick();
    tune_valid  = 1'b0;
  endtask

  // Returns ticks until done is seen; bound+1 when it never arrives.
  task automatic run_to_done(input int bound, output int n);
    n = bound + 1;
    for (int i = 1; i <= bound; i++) begin
      tick();
      if (done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic check_idle_reset(input string tag);
    check({tag, "_inc"},    phase_increment, 64'd0);
    check({tag, "_ready"},  64'(tune_ready), 64'd1);
    check({tag, "_locked"}, 64'(locked),     64'd0);
    check({tag, "_busy"},   64'(busy),       64'd0);
    check({tag, "_done"},   64'(done),       64'd0);
  endtask

  initial begin
    int n;
    int seen_done;
    logic [63:0] exp_inc;

    tick();
    tick();
    check_idle_reset("rst_hold");
    rst_n = 1'b1;
    tick();
    check_idle_reset("rst_rel");

`ifdef NCO_TUNE_RAMP_EN
    // Up-ramp 0 -> 100, step 30, dwell 2; a competing request during RAMP must be ignored
    request(64'd100, 64'd30, 16'd2);
    tune_valid  = 1'b1;
    tune_target = 64'd999;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (t == 1) check("ramp_ready", 64'(tune_ready), 64'd0);
      if (t == 4) tune_valid = 1'b0;
      exp_inc = (t < 3) ? 64'd0 : (t < 6) ? 64'd30 : (t < 9) ? 64'd60 : (t < 12) ? 64'd90 : 64'd100;
      check($sformatf("up_t%0d", t), phase_increment, exp_inc);
    end
    run_to_done(20, n);
    check("up_settle", 64'(n), 64'd8);
    check("up_locked", 64'(locked), 64'd1);
    check("up_ready",  64'(tune_ready), 64'd1);
    tick();
    check("up_done_pulse", 64'(done), 64'd0);

    // Down-ramp with step 0 jumps straight to target
    request(64'd10, 64'd0, 16'd0);
    check("dn_busy", 64'(busy), 64'd1);
    tick();
    check("dn_inc", phase_increment, 64'd10);
    run_to_done(20, n);
    check("dn_settle", 64'(n), 64'd8);
    check("dn_locked", 64'(locked), 64'd1);

    // Near-wrap: huge step must clamp at all-ones
    request(NEAR, 64'd0, 16'd0);
    run_to_done(20, n);
    check("nw_pre", phase_increment, NEAR);
    request(ALL1, HALF, 16'd1);
    tick();
    check("nw_hold", phase_increment, NEAR);
    tick();
    check("nw_inc", phase_increment, ALL1);
    run_to_done(20, n);
    check("nw_settle", 64'(n), 64'd8);
    check("nw_final", phase_increment, ALL1);

    // Abort mid-RAMP at 60 heading for 100
    request(64'd0, 64'd0, 16'd0);
    run_to_done(20, n);
    check("ab_pre", phase_increment, 64'd0);
    request(64'd100, 64'd30, 16'd0);
    tick();
    check("ab_s1", phase_increment, 64'd30);
    tick();
    check("ab_s2", phase_increment, 64'd60);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_inc",    phase_increment, 64'd60);
    check("ab_ready",  64'(tune_ready), 64'd1);
    check("ab_busy",   64'(busy), 64'd0);
    check("ab_locked", 64'(locked), 64'd0);
`else
    // Jump mode: target lands one cycle after acceptance; competing request ignored
    request(64'd500, 64'd3, 16'd4);
    check("j_inc0",  phase_increment, 64'd0);
    check("j_busy",  64'(busy), 64'd1);
    check("j_ready", 64'(tune_ready), 64'd0);
    tune_valid  = 1'b1;
    tune_target = 64'd7;
    tick();
    tune_valid  = 1'b0;
    check("j_inc1", phase_increment, 64'd500);
    for (int t = 0; t < 7; t++) tick();
    check("j_early_done", 64'(done), 64'd0);
    tick();
    check("j_done",   64'(done), 64'd1);
    check("j_locked", 64'(locked), 64'd1);
    check("j_ready2", 64'(tune_ready), 64'd1);
    tick();
    check("j_pulse",  64'(done), 64'd0);
    check("j_ignored", phase_increment, 64'd500);

    // Abort before the target is applied: increment holds
    request(64'd2000, 64'd0, 16'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_inc",    phase_increment, 64'd500);
    check("ab_busy",   64'(busy), 64'd0);
    check("ab_locked", 64'(locked), 64'd0);

    // Abort in IDLE alongside a request: request wins
    abort = 1'b1;
    request(64'd3000, 64'd0, 16'd0);
    abort = 1'b0;
    check("ia_busy", 64'(busy), 64'd1);
    run_to_done(30, n);
    check("ia_lat",    64'(n), 64'd9);
    check("ia_inc",    phase_increment, 64'd3000);
    check("ia_locked", 64'(locked), 64'd1);

    // Near-wrap target values pass through unchanged
    request(NEAR, 64'd0, 16'd0);
    run_to_done(30, n);
    request(ALL1, HALF, 16'd0);
    tick();
    check("nw_inc", phase_increment, ALL1);
    run_to_done(30, n);
    check("nw_lat", 64'(n), 64'd8);
`endif

    // Done must stay low after abort
    seen_done = 0;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (done) seen_done = 1;
    end
    check("post_no_done", 64'(seen_done), 64'd0);

    // Asynchronous reset mid-operation takes effect before any clock edge
    request(64'd123, 64'd0, 16'd0);
    tick();
    #2 rst_n = 1'b0;
    #1;
    check_idle_reset("arst");
    #1 rst_n = 1'b1;
    tick();
    check("arst_rel", phase_increment, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
